// File: rtl/wb_shared_bus_pkg.sv
// wb_shared_bus shared definitions: FSM encodings
// and the index-width helper used by the bus and arbiter.
package wb_shared_bus_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_OWNED = 1'b1;

   typedef struct packed {
      logic ack;
      logic err;
   } wb_rsp_t;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/wb_shared_bus_if.sv
// Packed multi-port Wishbone classic bundle; lane k of
// every vector belongs to port k.
interface wb_shared_bus_if #(
   parameter int N  = 1,
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int SW = DW / 8
);

   logic [N*AW-1:0] adr;
   logic [N*DW-1:0] dat_w;
   logic [N*DW-1:0] dat_r;
   logic [N*SW-1:0] sel;
   logic [N-1:0]    we;
   logic [N-1:0]    stb;
   logic [N-1:0]    cyc;
   logic [N-1:0]    ack;
   logic [N-1:0]    err;

   modport master (
      output adr, dat_w, sel, we, stb, cyc,
      input  dat_r, ack, err
   );

   modport slave (
      input  adr, dat_w, sel, we, stb, cyc,
      output dat_r, ack, err
   );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin search: first requester strictly after
// the last granted index, wrapping around.
module wb_rr_arbiter
   import wb_shared_bus_pkg::*;
#(
   parameter int NREQ = 2,
   localparam int IW = clog2_min1(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_last,
   input  logic            i_en,
   output logic [IW-1:0]   o_grant,
   output logic [NREQ-1:0] o_onehot
);

   logic w_found;
   int   w_j;

   always_comb begin
      o_grant  = '0;
      o_onehot = '0;
      w_found  = 1'b0;
      w_j      = 0;
      for (int k = 1; k <= NREQ; k++) begin
         w_j = (int'(i_last) + k) % NREQ;
         if (i_en && !w_found && i_req[w_j]) begin
            w_found       = 1'b1;
            o_grant       = IW'(w_j);
            o_onehot[w_j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_shared_bus.sv
// Multi-master Wishbone classic shared bus: round-robin
// tenure ownership, base/mask decode, miss and stall errors.
module wb_shared_bus
   import wb_shared_bus_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int NMASTERS     = 2,
   parameter int NSLAVES      = 5,
   parameter logic [NSLAVES*ADDR_WIDTH-1:0] DEVICE_ADDR = '0,
   parameter logic [NSLAVES*ADDR_WIDTH-1:0] DEVICE_MASK = '0,
   parameter int TIMEOUT_CYCLES = 255,
   localparam int MIW = clog2_min1(NMASTERS)
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   wb_shared_bus_if.slave  wbm,
   wb_shared_bus_if.master wbs,
   output logic [MIW-1:0]  bus_owner_o
);

   localparam int CW = clog2_min1(TIMEOUT_CYCLES + 1);
   localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
   localparam logic [CW-1:0] TO_LAST =
      CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   localparam int AW = ADDR_WIDTH;
   localparam int DW = DATA_WIDTH;
   localparam int SW = SELECT_WIDTH;

   logic [0:0]    r_state;
   logic [MIW-1:0] r_grant;
   logic [MIW-1:0] r_last;
   logic          r_err;
   logic          r_miss_hold;
   logic          r_to_err;
   logic [CW-1:0] r_cnt;

   logic                w_owned;
   logic                w_arb_en;
   logic                w_arb_any;
   logic [MIW-1:0]      w_arb_idx;
   logic [NMASTERS-1:0] w_arb_oh;
   logic [NMASTERS-1:0] w_own_oh;

   logic [AW-1:0] w_madr;
   logic [DW-1:0] w_mdat;
   logic [SW-1:0] w_msel;
   logic          w_mwe;
   logic          w_mstb;
   logic          w_mcyc;

   logic [NSLAVES-1:0] w_match;
   logic [NSLAVES-1:0] w_ssel;
   logic               w_hit;
   logic               w_sack;
   logic               w_serr;
   logic [DW-1:0]      w_sdat;

   logic w_ack;
   logic w_err;
   logic w_miss;
   logic w_stall;

   assign w_owned  = (r_state == ST_OWNED);
   assign w_arb_en = ~w_owned;

   wb_rr_arbiter #(
      .NREQ (NMASTERS)
   ) u_arb (
      .i_req    (wbm.cyc),
      .i_last   (r_last),
      .i_en     (w_arb_en),
      .o_grant  (w_arb_idx),
      .o_onehot (w_arb_oh)
   );

   assign w_arb_any = |w_arb_oh;

   // The owner's lane feeds every slave port.
   assign w_madr = wbm.adr[int'(r_grant)*AW +: AW];
   assign w_mdat = wbm.dat_w[int'(r_grant)*DW +: DW];
   assign w_msel = wbm.sel[int'(r_grant)*SW +: SW];
   assign w_mwe  = wbm.we[r_grant];
   assign w_mstb = wbm.stb[r_grant];
   assign w_mcyc = wbm.cyc[r_grant];

   always_comb begin
      w_match = '0;
      for (int i = 0; i < NSLAVES; i++) begin
         w_match[i] =
            (w_madr & DEVICE_MASK[i*AW +: AW]) ==
            DEVICE_ADDR[i*AW +: AW];
      end
   end

   // Lowest-index match wins overlapping windows.
   assign w_ssel = w_match & (~w_match + NSLAVES'(1));
   assign w_hit  = |w_match;

   assign w_sack = |(wbs.ack & w_ssel);
   assign w_serr = |(wbs.err & w_ssel);

   always_comb begin
      w_sdat = '0;
      for (int i = 0; i < NSLAVES; i++) begin
         if (w_ssel[i]) begin
            w_sdat = w_sdat | wbs.dat_r[i*DW +: DW];
         end
      end
   end

   assign wbs.adr   = {NSLAVES{w_madr}};
   assign wbs.dat_w = {NSLAVES{w_mdat}};
   assign wbs.sel   = {NSLAVES{w_msel}};
   assign wbs.we    = {NSLAVES{w_mwe}};
   assign wbs.cyc   = w_owned ? w_ssel : '0;
   assign wbs.stb   = (w_owned & w_mstb) ? w_ssel : '0;

   always_comb begin
      w_own_oh = '0;
      for (int k = 0; k < NMASTERS; k++) begin
         w_own_oh[k] = (r_grant == MIW'(k));
      end
   end

   assign w_ack = w_owned & w_sack;
   assign w_err = w_owned & (w_serr | r_err | r_to_err);

   assign wbm.ack   = w_ack ? w_own_oh : '0;
   assign wbm.err   = w_err ? w_own_oh : '0;
   assign wbm.dat_r = {NMASTERS{w_sdat}};

   assign bus_owner_o = r_grant;

   assign w_miss  = w_owned & w_mcyc & w_mstb & ~w_hit;
   assign w_stall = w_owned & w_mcyc & w_mstb &
                    ~w_ack & ~w_err;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state     <= ST_IDLE;
         r_grant     <= '0;
         r_last      <= MIW'(NMASTERS - 1);
         r_err       <= 1'b0;
         r_miss_hold <= 1'b0;
         r_to_err    <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_err    <= 1'b0;
         r_to_err <= 1'b0;
         unique case (1'b1)
            !w_owned: begin
               r_miss_hold <= 1'b0;
               r_cnt       <= '0;
               if (w_arb_any) begin
                  r_grant <= w_arb_idx;
                  r_last  <= w_arb_idx;
                  r_state <= ST_OWNED;
               end
            end
            w_owned: begin
               if (!w_mcyc) begin
                  r_state <= ST_IDLE;
               end
               // One miss error per stb assertion.
               r_miss_hold <= w_miss;
               r_err       <= w_miss & ~r_miss_hold;
               if (TO_EN && w_stall) begin
                  if (r_cnt == TO_LAST) begin
                     r_cnt    <= '0;
                     r_to_err <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end else begin
                  r_cnt <= '0;
               end
            end
         endcase
      end
   end

endmodule
